gameplay_fsm: RTL and testbench
===============================

Name: gameplay_fsm

Overview:
Parametrised successor to the gameplay game-over detector.
- Tracks the full game life-cycle: idle, play, player-hit pause, wave-clear pause and game over.
- Counts lives and waves; evaluates invader bitmap and row position once per video frame.
- Sits between the invaders block, the player/bullet collision logic and the display/score overlay; all outputs are registered.

Parameters:
N_COLS, 20, width of i_invaders_array (one bit per live invader in the lowest occupied row)
LINE_W, 4, width of i_invaders_line
GAME_OVER_LINE, 13, invasion threshold; row index >= this with any invader alive ends the game
LIVES, 3, lives at game start (>=1)
HIT_FRAMES, 60, frames spent in HIT pause (>=1)
CLEAR_FRAMES, 120, frames spent in WAVE_CLEAR pause (>=1)
WAVE_W, 4, width of wave counter (saturating)

Ports:
i_clk_36MHz  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_frame_tick  in  1  one-cycle pulse at end of each frame; evaluation strobe
i_start  in  1  start/restart request (level, sampled every cycle)
i_player_hit  in  1  one-cycle pulse: player struck by invader bullet
i_invaders_array  in  N_COLS  live-invader bitmap of lowest occupied row; all-zero = wave destroyed
i_invaders_line  in  LINE_W  row index of lowest occupied row
o_state  out  3  0 IDLE, 1 PLAY, 2 HIT, 3 WAVE_CLEAR, 4 GAME_OVER
o_lives  out  clog2(LIVES+1)  remaining lives
o_wave  out  WAVE_W  waves cleared, saturates at all-ones
o_wave_start  out  1  one-cycle pulse: invaders block must reload formation
o_game_over  out  1  high exactly while o_state==GAME_OVER

Behaviour:
- Reset (async assert, sync-to-clock deassert irrelevant here):
  - o_state=IDLE, o_lives=0, o_wave=0, o_wave_start=0, o_game_over=0.
  - Pause counter=0, hit_pending=0.
  - Reset mid-game aborts immediately to these values.
- IDLE or GAME_OVER with i_start=1 (any cycle, no tick needed):
  - Next cycle o_state=PLAY, o_lives=LIVES, o_wave=0, o_wave_start=1 for one cycle, hit_pending=0.
- hit_pending:
  - Set by i_player_hit on any PLAY cycle.
  - Cleared on every frame-tick evaluation in PLAY, and on entry to PLAY.
  - i_player_hit outside PLAY is ignored.
- PLAY, on i_frame_tick (cycle with i_player_hit=1 and tick counts as pending). Priority order:
  1. Invasion: i_invaders_line >= GAME_OVER_LINE and array != 0 -> GAME_OVER; lives unchanged.
  2. Hit pending: lives decremented. If result is 0 -> GAME_OVER. Else -> HIT, counter=HIT_FRAMES.
  3. Array == 0 -> WAVE_CLEAR, counter=CLEAR_FRAMES, o_wave incremented (saturating).
  4. Otherwise stay in PLAY.
- PLAY without tick: no state change.
- HIT and WAVE_CLEAR pauses:
  - Each tick decrements the counter. The tick with counter==1 transitions to PLAY, so the pause is exactly N ticks.
  - WAVE_CLEAR->PLAY asserts o_wave_start for one cycle. HIT->PLAY does not.
  - i_start is ignored in HIT, WAVE_CLEAR and PLAY.
- GAME_OVER: held until i_start; o_lives, o_wave frozen for score display.
- Latency: every output updates on the clock edge after the evaluating cycle (1 cycle).
- Illegal o_state encodings (5-7) recover to IDLE on the next cycle.
- Formal properties shipped with the block:
  - o_game_over == (o_state==4).
  - o_lives never exceeds LIVES.
  - o_lives==0 implies state IDLE or GAME_OVER.
  - o_wave_start implies o_state==PLAY.

Decomposition:
- Shared package gameplay_pkg holds:
  - state encoding constants ST_IDLE..ST_GAME_OVER and the state type;
  - the default GAME_OVER_LINE, used also by the invaders and display blocks.
- One sub-module is natural: frame_pause_counter (load value, tick decrement, one-cycle done flag). It is instantiated once and shared by HIT and WAVE_CLEAR, loaded with the appropriate constant.

Test Plan:
- Reset then i_start pulse -> next cycle o_state=1, o_lives=3, o_wave=0, o_wave_start=1 for exactly 1 cycle.
- PLAY, array=20'h00001, line=13, tick -> o_state=4, o_game_over=1, o_lives=3. Same with line=12 -> stays PLAY. Same with line=13 and array=0 -> WAVE_CLEAR, not game over.
- PLAY, 3 hits each followed by a tick and full HIT pause (HIT_FRAMES=2 in bench):
  - o_lives 3->2->1->0.
  - HIT lasts exactly 2 ticks.
  - Third hit goes straight to GAME_OVER.
- Array=0 on tick -> WAVE_CLEAR, o_wave=1. After CLEAR_FRAMES ticks -> PLAY with o_wave_start pulse. Bench runs 17 clears (WAVE_W=4) -> o_wave saturates at 15.
- Simultaneous hit, array=0 and invasion (line=14) on the same tick -> GAME_OVER. Hit and array=0 with line=5 -> HIT, o_wave unchanged.
- i_reset_n low mid-HIT with counter=1 -> IDLE, lives 0, no o_wave_start. GAME_OVER + i_start -> PLAY, lives=LIVES, wave=0.

Source files
------------

// File: rtl/gameplay_pkg.sv
// Shared gameplay definitions: state encoding and the invasion row threshold
// also used by the invaders and display blocks.
package gameplay_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PLAY       = 3'd1,
        ST_HIT        = 3'd2,
        ST_WAVE_CLEAR = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_t;

    localparam int DEFAULT_GAME_OVER_LINE = 13;

endpackage

// File: rtl/frame_pause_counter.sv
// Frame-tick down-counter for timed pauses; done flags the tick that ends the pause.
module frame_pause_counter #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // A zero count can never strand a pause: it ends on the next tick as well.
    assign done = tick && (count <= CNT_W'(1));

endmodule

// File: rtl/gameplay_fsm.sv
// Game life-cycle controller: idle, play, hit pause, wave-clear pause and game over,
// with lives and wave counting evaluated once per video frame.
module gameplay_fsm
    import gameplay_pkg::*;
#(
    parameter int N_COLS         = 20,
    parameter int LINE_W         = 4,
    parameter int GAME_OVER_LINE = DEFAULT_GAME_OVER_LINE,
    parameter int LIVES          = 3,
    parameter int HIT_FRAMES     = 60,
    parameter int CLEAR_FRAMES   = 120,
    parameter int WAVE_W         = 4
) (
    input  logic                         i_clk_36MHz,
    input  logic                         i_reset_n,
    input  logic                         i_frame_tick,
    input  logic                         i_start,
    input  logic                         i_player_hit,
    input  logic [N_COLS-1:0]            i_invaders_array,
    input  logic [LINE_W-1:0]            i_invaders_line,
    output logic [2:0]                   o_state,
    output logic [$clog2(LIVES+1)-1:0]   o_lives,
    output logic [WAVE_W-1:0]            o_wave,
    output logic                         o_wave_start,
    output logic                         o_game_over
);

    localparam int LIVES_W   = $clog2(LIVES + 1);
    localparam int PAUSE_MAX = (HIT_FRAMES > CLEAR_FRAMES) ? HIT_FRAMES : CLEAR_FRAMES;
    localparam int PAUSE_W   = $clog2(PAUSE_MAX + 1);

    state_t               state;
    logic [LIVES_W-1:0]   lives;
    logic [WAVE_W-1:0]    wave;
    logic                 wave_start;
    logic                 game_over;
    logic                 hit_pending;

    logic                 invasion;
    logic                 wave_cleared;
    logic                 hit_now;
    logic                 last_life;
    logic                 pause_load;
    logic [PAUSE_W-1:0]   pause_value;
    logic                 pause_tick;
    logic                 pause_done;

    assign invasion     = (int'(i_invaders_line) >= GAME_OVER_LINE) && (i_invaders_array != '0);
    assign wave_cleared = (i_invaders_array == '0);
    assign hit_now      = hit_pending || i_player_hit;
    assign last_life    = (lives <= LIVES_W'(1));
    assign pause_tick   = i_frame_tick && (state == ST_HIT || state == ST_WAVE_CLEAR);

    // Mirrors the PLAY priority chain so the shared counter is loaded on the same edge.
    always_comb begin
        pause_load  = 1'b0;
        pause_value = '0;
        if (state == ST_PLAY && i_frame_tick && !invasion) begin
            if (hit_now) begin
                if (!last_life) begin
                    pause_load  = 1'b1;
                    pause_value = PAUSE_W'(HIT_FRAMES);
                end
            end else if (wave_cleared) begin
                pause_load  = 1'b1;
                pause_value = PAUSE_W'(CLEAR_FRAMES);
            end
        end
    end

    frame_pause_counter #(
        .CNT_W(PAUSE_W)
    ) u_pause (
        .clk        (i_clk_36MHz),
        .rst_n      (i_reset_n),
        .load       (pause_load),
        .load_value (pause_value),
        .tick       (pause_tick),
        .done       (pause_done)
    );

    always_ff @(posedge i_clk_36MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            lives       <= '0;
            wave        <= '0;
            wave_start  <= 1'b0;
            game_over   <= 1'b0;
            hit_pending <= 1'b0;
        end else begin
            wave_start <= 1'b0;
            game_over  <= 1'b0;
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (i_start) begin
                        state       <= ST_PLAY;
                        lives       <= LIVES_W'(LIVES);
                        wave        <= '0;
                        wave_start  <= 1'b1;
                        hit_pending <= 1'b0;
                    end else begin
                        game_over <= (state == ST_GAME_OVER);
                    end
                end
                ST_PLAY: begin
                    if (i_frame_tick) begin
                        hit_pending <= 1'b0;
                        if (invasion) begin
                            state     <= ST_GAME_OVER;
                            game_over <= 1'b1;
                        end else if (hit_now) begin
                            lives <= lives - 1'b1;
                            if (last_life) begin
                                state     <= ST_GAME_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state <= ST_HIT;
                            end
                        end else if (wave_cleared) begin
                            state <= ST_WAVE_CLEAR;
                            if (wave != '1) begin
                                wave <= wave + 1'b1;
                            end
                        end
                    end else if (i_player_hit) begin
                        hit_pending <= 1'b1;
                    end
                end
                ST_HIT: begin
                    if (pause_done) begin
                        state       <= ST_PLAY;
                        hit_pending <= 1'b0;
                    end
                end
                ST_WAVE_CLEAR: begin
                    if (pause_done) begin
                        state       <= ST_PLAY;
                        wave_start  <= 1'b1;
                        hit_pending <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_state      = state;
    assign o_lives      = lives;
    assign o_wave       = wave;
    assign o_wave_start = wave_start;
    assign o_game_over  = game_over;

    // Invariants relied on by the display and invaders blocks.
    a_game_over_flag: assert property (@(posedge i_clk_36MHz) disable iff (!i_reset_n)
        o_game_over == (o_state == 3'd4));
    a_lives_bound: assert property (@(posedge i_clk_36MHz) disable iff (!i_reset_n)
        o_lives <= LIVES_W'(LIVES));
    a_no_lives_idle: assert property (@(posedge i_clk_36MHz) disable iff (!i_reset_n)
        (o_lives == '0) |-> (o_state == 3'd0 || o_state == 3'd4));
    a_wave_start_play: assert property (@(posedge i_clk_36MHz) disable iff (!i_reset_n)
        o_wave_start |-> (o_state == 3'd1));

endmodule

// File: tb/tb_gameplay_fsm.sv
// Scoreboard bench for gameplay_fsm with short pauses (HIT_FRAMES=2, CLEAR_FRAMES=3).
module tb_gameplay_fsm;

    typedef struct packed {
        logic        tick;
        logic        start;
        logic        hit;
        logic [19:0] arr;
        logic [3:0]  line;
    } stim_t;

    logic        clk;
    logic        i_reset_n;
    logic        i_frame_tick;
    logic        i_start;
    logic        i_player_hit;
    logic [19:0] i_invaders_array;
    logic [3:0]  i_invaders_line;
    logic [2:0]  o_state;
    logic [1:0]  o_lives;
    logic [3:0]  o_wave;
    logic        o_wave_start;
    logic        o_game_over;

    int checks   = 0;
    int failures = 0;
    logic [10:0] sb[$];

    gameplay_fsm #(
        .HIT_FRAMES   (2),
        .CLEAR_FRAMES (3)
    ) dut (
        .i_clk_36MHz      (clk),
        .i_reset_n        (i_reset_n),
        .i_frame_tick     (i_frame_tick),
        .i_start          (i_start),
        .i_player_hit     (i_player_hit),
        .i_invaders_array (i_invaders_array),
        .i_invaders_line  (i_invaders_line),
        .o_state          (o_state),
        .o_lives          (o_lives),
        .o_wave           (o_wave),
        .o_wave_start     (o_wave_start),
        .o_game_over      (o_game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t S(input bit tick, input bit start, input bit hit,
                                input logic [19:0] arr, input logic [3:0] line);
        stim_t s;
        s.tick  = tick;
        s.start = start;
        s.hit   = hit;
        s.arr   = arr;
        s.line  = line;
        return s;
    endfunction

    function automatic logic [10:0] E(input int st, input int lv, input int wv,
                                      input bit ws, input bit go);
        return {3'(st), 2'(lv), 4'(wv), ws, go};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic drive(input stim_t s);
        i_frame_tick     = s.tick;
        i_start          = s.start;
        i_player_hit     = s.hit;
        i_invaders_array = s.arr;
        i_invaders_line  = s.line;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] got, want;
        i_reset_n = 1'b0;
        drive_idle_inputs();
        #2;
        sb.push_back(E(0, 0, 0, 0, 0));
        got  = {o_state, o_lives, o_wave, o_wave_start, o_game_over};
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL reset: got %h want %h", got, want);
        end
        repeat (2) @(posedge clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    task automatic drive_idle_inputs();
        i_frame_tick     = 1'b0;
        i_start          = 1'b0;
        i_player_hit     = 1'b0;
        i_invaders_array = 20'h0;
        i_invaders_line  = 4'd0;
    endtask

    task automatic test_start();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] got, want;
        st.push_back(S(1, 0, 0, 20'h1, 0)); ex.push_back(E(0, 0, 0, 0, 0));
        st.push_back(S(0, 1, 0, 20'h1, 0)); ex.push_back(E(1, 3, 0, 1, 0));
        st.push_back(S(0, 0, 0, 20'h1, 0)); ex.push_back(E(1, 3, 0, 0, 0));
        st.push_back(S(0, 1, 0, 20'h1, 0)); ex.push_back(E(1, 3, 0, 0, 0));
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = {o_state, o_lives, o_wave, o_wave_start, o_game_over};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL start step %0d: got st=%0d lv=%0d wv=%0d ws=%b go=%b want st=%0d lv=%0d wv=%0d ws=%b go=%b",
                         i, got[10:8], got[7:6], got[5:2], got[1], got[0],
                         want[10:8], want[7:6], want[5:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_invasion();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] got, want;
        st.push_back(S(1, 0, 0, 20'h1, 12)); ex.push_back(E(1, 3, 0, 0, 0));
        st.push_back(S(1, 0, 0, 20'h1, 13)); ex.push_back(E(4, 3, 0, 0, 1));
        st.push_back(S(0, 0, 0, 20'h1, 13)); ex.push_back(E(4, 3, 0, 0, 1));
        st.push_back(S(0, 1, 0, 20'h1, 0));  ex.push_back(E(1, 3, 0, 1, 0));
        st.push_back(S(1, 0, 0, 20'h0, 13)); ex.push_back(E(3, 3, 1, 0, 0));
        st.push_back(S(0, 0, 0, 20'h0, 0));  ex.push_back(E(3, 3, 1, 0, 0));
        st.push_back(S(1, 0, 0, 20'h0, 0));  ex.push_back(E(3, 3, 1, 0, 0));
        st.push_back(S(1, 0, 0, 20'h0, 0));  ex.push_back(E(3, 3, 1, 0, 0));
        st.push_back(S(1, 0, 0, 20'h0, 0));  ex.push_back(E(1, 3, 1, 1, 0));
        st.push_back(S(0, 0, 0, 20'h1, 0));  ex.push_back(E(1, 3, 1, 0, 0));
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = {o_state, o_lives, o_wave, o_wave_start, o_game_over};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL invasion step %0d: got st=%0d lv=%0d wv=%0d ws=%b go=%b want st=%0d lv=%0d wv=%0d ws=%b go=%b",
                         i, got[10:8], got[7:6], got[5:2], got[1], got[0],
                         want[10:8], want[7:6], want[5:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_hits();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] got, want;
        st.push_back(S(0, 0, 1, 20'h1, 0)); ex.push_back(E(1, 3, 1, 0, 0));
        st.push_back(S(1, 0, 0, 20'h1, 0)); ex.push_back(E(2, 2, 1, 0, 0));
        st.push_back(S(0, 1, 0, 20'h1, 0)); ex.push_back(E(2, 2, 1, 0, 0));
        st.push_back(S(0, 0, 1, 20'h1, 0)); ex.push_back(E(2, 2, 1, 0, 0));
        st.push_back(S(1, 0, 0, 20'h1, 0)); ex.push_back(E(2, 2, 1, 0, 0));
        st.push_back(S(1, 0, 0, 20'h1, 0)); ex.push_back(E(1, 2, 1, 0, 0));
        st.push_back(S(1, 0, 0, 20'h1, 0)); ex.push_back(E(1, 2, 1, 0, 0));
        st.push_back(S(1, 0, 1, 20'h1, 0)); ex.push_back(E(2, 1, 1, 0, 0));
        st.push_back(S(1, 0, 0, 20'h1, 0)); ex.push_back(E(2, 1, 1, 0, 0));
        st.push_back(S(1, 0, 0, 20'h1, 0)); ex.push_back(E(1, 1, 1, 0, 0));
        st.push_back(S(0, 0, 1, 20'h1, 0)); ex.push_back(E(1, 1, 1, 0, 0));
        st.push_back(S(1, 0, 0, 20'h1, 0)); ex.push_back(E(4, 0, 1, 0, 1));
        st.push_back(S(1, 0, 1, 20'h0, 0)); ex.push_back(E(4, 0, 1, 0, 1));
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = {o_state, o_lives, o_wave, o_wave_start, o_game_over};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL hits step %0d: got st=%0d lv=%0d wv=%0d ws=%b go=%b want st=%0d lv=%0d wv=%0d ws=%b go=%b",
                         i, got[10:8], got[7:6], got[5:2], got[1], got[0],
                         want[10:8], want[7:6], want[5:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_wave_saturation();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] got, want;
        int w;
        st.push_back(S(0, 1, 0, 20'h1, 0)); ex.push_back(E(1, 3, 0, 1, 0));
        for (int k = 1; k <= 17; k++) begin
            w = (k > 15) ? 15 : k;
            st.push_back(S(1, 0, 0, 20'h0, 0)); ex.push_back(E(3, 3, w, 0, 0));
            st.push_back(S(1, 0, 0, 20'h0, 0)); ex.push_back(E(3, 3, w, 0, 0));
            st.push_back(S(1, 0, 0, 20'h0, 0)); ex.push_back(E(3, 3, w, 0, 0));
            st.push_back(S(1, 0, 0, 20'h0, 0)); ex.push_back(E(1, 3, w, 1, 0));
        end
        st.push_back(S(1, 0, 0, 20'h1, 13)); ex.push_back(E(4, 3, 15, 0, 1));
        st.push_back(S(0, 0, 0, 20'h1, 0));  ex.push_back(E(4, 3, 15, 0, 1));
        st.push_back(S(0, 1, 0, 20'h1, 0));  ex.push_back(E(1, 3, 0, 1, 0));
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = {o_state, o_lives, o_wave, o_wave_start, o_game_over};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL wave step %0d: got st=%0d lv=%0d wv=%0d ws=%b go=%b want st=%0d lv=%0d wv=%0d ws=%b go=%b",
                         i, got[10:8], got[7:6], got[5:2], got[1], got[0],
                         want[10:8], want[7:6], want[5:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_reset_mid_hit();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] got, want;
        st.push_back(S(1, 0, 1, 20'h1, 0)); ex.push_back(E(2, 2, 0, 0, 0));
        st.push_back(S(1, 0, 0, 20'h1, 0)); ex.push_back(E(2, 2, 0, 0, 0));
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = {o_state, o_lives, o_wave, o_wave_start, o_game_over};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL mid_hit step %0d: got %h want %h", i, got, want);
            end
        end
        // Counter is now 1: the next tick would have ended the pause.
        i_reset_n = 1'b0;
        #1;
        sb.push_back(E(0, 0, 0, 0, 0));
        got  = {o_state, o_lives, o_wave, o_wave_start, o_game_over};
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL mid_hit async reset: got %h want %h", got, want);
        end
        sb.push_back(E(0, 0, 0, 0, 0));
        drive(S(1, 0, 0, 20'h1, 0));
        i_reset_n = 1'b1;
        got  = {o_state, o_lives, o_wave, o_wave_start, o_game_over};
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL mid_hit held reset: got %h want %h", got, want);
        end
        sb.push_back(E(0, 0, 0, 0, 0));
        drive(S(1, 0, 0, 20'h1, 0));
        got  = {o_state, o_lives, o_wave, o_wave_start, o_game_over};
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL mid_hit after release: got %h want %h", got, want);
        end
    endtask

    task automatic test_priority();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] got, want;
        st.push_back(S(0, 1, 0, 20'h1, 0));  ex.push_back(E(1, 3, 0, 1, 0));
        st.push_back(S(1, 0, 1, 20'h1, 14)); ex.push_back(E(4, 3, 0, 0, 1));
        st.push_back(S(0, 1, 0, 20'h1, 0));  ex.push_back(E(1, 3, 0, 1, 0));
        st.push_back(S(1, 0, 1, 20'h0, 5));  ex.push_back(E(2, 2, 0, 0, 0));
        st.push_back(S(1, 0, 0, 20'h0, 5));  ex.push_back(E(2, 2, 0, 0, 0));
        st.push_back(S(1, 0, 0, 20'h1, 5));  ex.push_back(E(1, 2, 0, 0, 0));
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = {o_state, o_lives, o_wave, o_wave_start, o_game_over};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL priority step %0d: got st=%0d lv=%0d wv=%0d ws=%b go=%b want st=%0d lv=%0d wv=%0d ws=%b go=%b",
                         i, got[10:8], got[7:6], got[5:2], got[1], got[0],
                         want[10:8], want[7:6], want[5:2], want[1], want[0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_start();
        test_invasion();
        test_hits();
        test_wave_saturation();
        test_reset_mid_hit();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
